// File: rtl/gpio_in_filter.sv
// GPIO pad input conditioner: per-pin synchronizer plus tick-paced stability filter.
// Filtered levels and one-cycle change pulses go to the GPIO controller.

module gpio_in_filter_lane #(
  parameter int SYNC_STAGE = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 pad,
  input  logic                 en,
  input  logic                 tick,
  input  logic [CNT_WIDTH-1:0] thresh,
  output logic                 q,
  output logic                 chg
);
  logic [SYNC_STAGE-1:0] sync;
  logic [CNT_WIDTH-1:0]  c, c_nxt;
  logic                  s, q_nxt;

  assign s = sync[SYNC_STAGE-1];

  always_comb begin
    q_nxt = q;
    c_nxt = c;
    if (!en) begin
      q_nxt = s;
      c_nxt = '0;
    end else if (s == q) begin
      c_nxt = '0;
    end else if (tick) begin
      // c stays bounded by thresh, so a lowered thresh accepts on the next tick
      if (c >= thresh) begin
        q_nxt = s;
        c_nxt = '0;
      end else begin
        c_nxt = c + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync <= '0;
      c    <= '0;
      q    <= 1'b0;
      chg  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGE-2:0], pad};
      c    <= c_nxt;
      q    <= q_nxt;
      chg  <= q_nxt != q;
    end
  end
endmodule

module gpio_in_filter #(
  parameter int PIN_NUM    = 32,
  parameter int SYNC_STAGE = 2,
  parameter int CNT_WIDTH  = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [PIN_NUM-1:0]   gpio_in_i,
  input  logic [PIN_NUM-1:0]   filt_en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [CNT_WIDTH-1:0] thresh_i,
  output logic [PIN_NUM-1:0]   gpio_in_o,
  output logic [PIN_NUM-1:0]   chg_o
);
  logic [DIV_WIDTH-1:0] pcnt;
  logic                 tick;

  // >= rather than == so a lowered div_i ticks at once instead of wrapping
  assign tick = pcnt >= div_i;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) pcnt <= '0;
    else          pcnt <= tick ? '0 : pcnt + 1'b1;
  end

  for (genvar i = 0; i < PIN_NUM; i++) begin : g_lane
    gpio_in_filter_lane #(
      .SYNC_STAGE(SYNC_STAGE),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_lane (
      .pclk   (pclk),
      .presetn(presetn),
      .pad    (gpio_in_i[i]),
      .en     (filt_en_i[i]),
      .tick   (tick),
      .thresh (thresh_i),
      .q      (gpio_in_o[i]),
      .chg    (chg_o[i])
    );
  end
endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: step, glitch, prescaler, bypass, reset and threshold cases.
`timescale 1ns/1ps
module tb_gpio_in_filter;
  logic        pclk, presetn;
  logic [31:0] gpio_in_i, filt_en_i, gpio_in_o, chg_o;
  logic [15:0] div_i;
  logic [7:0]  thresh_i;
  int          n_chk, n_err;
  logic [15:0] mp;

  gpio_in_filter dut (
    .pclk(pclk), .presetn(presetn), .gpio_in_i(gpio_in_i), .filt_en_i(filt_en_i),
    .div_i(div_i), .thresh_i(thresh_i), .gpio_in_o(gpio_in_o), .chg_o(chg_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // reference prescaler phase
  always @(posedge pclk or negedge presetn)
    if (!presetn) mp <= '0;
    else          mp <= (mp >= div_i) ? 16'd0 : mp + 16'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // set pin to val, expect output change (and pulse) at edge exp_e
  task automatic step(input int pin, input logic val, input int exp_e);
    gpio_in_i[pin] = val;
    for (int e = 1; e <= exp_e + 1; e++) begin
      cyc(1);
      chk($sformatf("step p%0d v%0b e%0d q", pin, val, e), 32'(gpio_in_o[pin]),
          32'((e >= exp_e) ? val : !val));
      chk($sformatf("step p%0d v%0b e%0d chg", pin, val, e), 32'(chg_o[pin]), 32'(e == exp_e));
    end
  endtask

  // drive a width-cycle high pulse on mask pins; pin follows rise/fall edges, other mask pins stay 0
  task automatic pulse(input logic [31:0] mask, input int width, input int pin,
                       input int rise, input int fall, input int n);
    logic [31:0] oth;
    oth = mask & ~(32'd1 << pin);
    gpio_in_i = gpio_in_i | mask;
    for (int e = 1; e <= n; e++) begin
      cyc(1);
      if (e == width) gpio_in_i = gpio_in_i & ~mask;
      chk($sformatf("pulse w%0d p%0d e%0d q", width, pin, e), 32'(gpio_in_o[pin]),
          32'(rise != 0 && e >= rise && e < fall));
      chk($sformatf("pulse w%0d p%0d e%0d chg", width, pin, e), 32'(chg_o[pin]),
          32'(rise != 0 && (e == rise || e == fall)));
      chk($sformatf("pulse w%0d e%0d others", width, e), (gpio_in_o | chg_o) & oth, 32'd0);
    end
  endtask

  initial begin
    int acc, nt;
    logic tk;
    n_chk = 0; n_err = 0;
    presetn = 1'b0; gpio_in_i = '0; filt_en_i = '1; div_i = '0; thresh_i = 8'd3;
    #1;
    chk("rst q", gpio_in_o, 32'd0);
    chk("rst chg", chg_o, 32'd0);
    cyc(3);
    presetn = 1'b1;
    cyc(5);
    chk("idle q", gpio_in_o, 32'd0);

    // step filtered
    step(0, 1'b1, 6);
    cyc(3);
    step(0, 1'b0, 6);
    cyc(3);

    // glitch reject and accept
    pulse(32'd1 << 5, 3, 5, 0, 0, 12);
    pulse(32'd1 << 5, 4, 5, 6, 10, 14);
    cyc(3);

    // prescaler
    div_i = 16'd9; thresh_i = 8'd1;
    cyc(20);
    gpio_in_i[3] = 1'b1;
    acc = 0; nt = 0;
    for (int k = 1; k <= 24; k++) begin
      tk = (mp >= div_i);
      if (k >= 3 && tk) nt++;
      if (nt == 2 && acc == 0) acc = k;
      cyc(1);
      chk($sformatf("pre e%0d q", k), 32'(gpio_in_o[3]), 32'(acc != 0));
      chk($sformatf("pre e%0d chg", k), 32'(chg_o[3]), 32'(acc == k));
    end
    chk("pre window", 32'(acc >= 13 && acc <= 22), 32'd1);
    gpio_in_i[3] = 1'b0;
    cyc(30);
    chk("pre fall", 32'(gpio_in_o[3]), 32'd0);
    div_i = '0; thresh_i = 8'd3;
    cyc(3);

    // bypass on pin 7, filtered neighbours ignore the pulse
    filt_en_i = ~(32'd1 << 7);
    pulse((32'd1 << 7) | (32'd1 << 6) | (32'd1 << 1), 1, 7, 3, 4, 8);
    gpio_in_i[7] = 1'b0;
    filt_en_i = '1;
    cyc(2);
    chk("mode sw chg", chg_o, 32'd0);

    // reset mid-count
    thresh_i = 8'd200;
    gpio_in_i[0] = 1'b1;
    cyc(100);
    chk("mid q", 32'(gpio_in_o[0]), 32'd0);
    presetn = 1'b0;
    #1;
    chk("mid rst q", gpio_in_o, 32'd0);
    chk("mid rst chg", chg_o, 32'd0);
    cyc(2);
    chk("mid rst hold", gpio_in_o | chg_o, 32'd0);
    presetn = 1'b1;
    cyc(202);
    chk("post rst e202 q", 32'(gpio_in_o[0]), 32'd0);
    cyc(1);
    chk("post rst e203 q", 32'(gpio_in_o[0]), 32'd1);
    chk("post rst e203 chg", 32'(chg_o[0]), 32'd1);
    cyc(1);
    chk("post rst e204 chg", 32'(chg_o[0]), 32'd0);
    gpio_in_i[0] = 1'b0;
    thresh_i = 8'd3;
    cyc(10);
    chk("post rst clear", gpio_in_o, 32'd0);

    // threshold lowered mid-count
    thresh_i = 8'd100;
    gpio_in_i[2] = 1'b1;
    cyc(52);
    chk("thr e52 q", 32'(gpio_in_o[2]), 32'd0);
    thresh_i = 8'd10;
    cyc(1);
    chk("thr e53 q", 32'(gpio_in_o[2]), 32'd1);
    chk("thr e53 chg", chg_o, 32'd1 << 2);
    cyc(1);
    chk("thr e54 chg", chg_o, 32'd0);
    chk("thr e54 q", gpio_in_o, 32'd1 << 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
